p4_arbiter: RTL and testbench
=============================

// Module: p4_arbiter
// PURPOSE
//  Index-driven 4:1 packet arbiter for the P4 aggregation datapath. The io_idx stream picks which input
//  port to drain next. The selected port's packets are forwarded to io_out in arrival order. A burst ends
//  after the first packet with is_empty==0, including that packet. Sits between per-port P4 stages and
//  the downstream single-stream consumer.
// PARAMETERS
//  N_IN      4    number of input ports (fixed; idx width = 2)
//  PKT_W     113  packed packet width {eth_type[15:0], next_idx[31:0], bitmap[31:0], index[31:0], is_empty}
// PORTS
//  clock                      in   1   system clock, all logic rising-edge
//  reset                      in   1   asynchronous, active-high reset
//  io_in_k_valid (k=0..3)     in   1   input k packet valid
//  io_in_k_ready (k=0..3)     out  1   input k accept
//  io_in_k_bits_head_eth_type in   16  input k field
//  io_in_k_bits_head_next_idx in   32  input k field
//  io_in_k_bits_head_bitmap   in   32  input k field
//  io_in_k_bits_head_index    in   32  input k field
//  io_in_k_bits_is_empty      in   1   1 = no payload (not a burst terminator)
//  io_out_valid/ready         out/in 1 output handshake
//  io_out_bits_*              out  16/32/32/32/1  same fields as inputs, passed unmodified
//  io_idx_valid/ready         in/out 1 selection-command handshake
//  io_idx_bits                in   2   input port to drain next
// BEHAVIOUR
//  - Handshakes: ready/valid; transfer on valid&&ready at rising edge; valid never depends on ready.
//  - States: IDLE, BUSY. sel register holds 2 bits.
//  - IDLE: io_idx_ready=1 and all io_in_k_ready=0. On idx fire: sel<=io_idx_bits, go to BUSY.
//  - BUSY: io_idx_ready=0. io_in_sel_ready = out_slot_free, where out_slot_free = !io_out_valid || io_out_ready.
//    All other io_in_k_ready stay 0.
//  - BUSY on input fire: load the packet into the output register and set io_out_valid.
//    If is_empty==0, return to IDLE the next cycle; if is_empty==1, stay in BUSY.
//  - Output register: latency is 1 cycle from input fire to io_out_valid. Full throughput: load and
//    drain in the same cycle is allowed. io_out_valid clears on io_out_ready with no new load.
//  - Output bits stay stable while io_out_valid && !io_out_ready.
//  - Empty packets are forwarded, not dropped. Fields are not modified. Order within a port is preserved.
//  - Packets on unselected ports wait and are never lost. An idx arriving in BUSY stalls until IDLE.
//  - Minimum 1 IDLE cycle between bursts.
//  - Reset (async, any time): state=IDLE, sel=0, io_out_valid=0, io_out_bits=0, all io_in_k_ready=0,
//    io_idx_ready=0 while reset is high. Any in-flight burst is abandoned.
//  - Same index twice in a row is legal: the second burst starts at that port's next packet.
// STRUCTURE
//  - Shared package p4_pkg: typedef struct packed p4_head_t {eth_type, next_idx, bitmap, index};
//    typedef struct packed p4_pkt_t {p4_head_t head; logic is_empty}; localparam P4_N_IN=4.
//  - One sub-module p4_reg_slice: a PKT_W-wide 1-entry pipeline register with ready/valid,
//    used for the output stage.
//  - Top level holds the state machine, sel register and input mux.
// TESTING
//  - Single burst: in0 gets {eth=0,empty=0}; idx=0 -> one output with eth=0, empty=0; FSM back to
//    IDLE; in1..3 ready stay 0.
//  - Multi-packet burst: in3 gets empty=1, empty=1, empty=0; idx=3 -> 3 outputs in order, eth=3,
//    flags 1,1,0; next idx accepted only afterwards.
//  - Mixed sequence: in0 {0,1,0}, in1 {1,1,0,1,1}, in2 {0,1,1}, in3 {1,1,0} (is_empty flags) preloaded;
//    idx 0,2,1,3,0 -> output eth sequence 0; 2; 1,1,1; 3,3,3; 0,0. Leftover in1 (2 pkts) and in2
//    (2 pkts) remain pending.
//  - Backpressure: io_out_ready toggled randomly during a burst -> no loss or duplication, bits stable
//    while stalled.
//  - idx with empty port: idx=2, in2 idle 50 cycles then a packet arrives -> arbiter waits in BUSY;
//    other ports stay blocked.
//  - Reset mid-burst: assert reset with io_out_valid=1 -> io_out_valid=0 and all readies 0
//    immediately; after release, io_idx_ready=1.

Source files
------------

// File: rtl/p4_pkg.sv
// Shared types for the P4 aggregation datapath: packet layout, port count and
// arbiter state encoding.
package p4_pkg;

  localparam int P4_N_IN  = 4;
  localparam int P4_IDX_W = 2;

  typedef struct packed {
    logic [15:0] eth_type;
    logic [31:0] next_idx;
    logic [31:0] bitmap;
    logic [31:0] index;
  } p4_head_t;

  typedef struct packed {
    p4_head_t head;
    logic     is_empty;
  } p4_pkt_t;

  localparam int P4_PKT_W = $bits(p4_pkt_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } p4_state_t;

  // A packet carrying payload closes the burst it belongs to.
  function automatic logic is_burst_end(input p4_pkt_t pkt);
    return !pkt.is_empty;
  endfunction

endpackage

// File: rtl/p4_reg_slice.sv
// One-entry ready/valid pipeline register. It accepts a new word whenever it is
// empty or being drained in the same cycle, so it sustains full throughput.
module p4_reg_slice #(
  parameter int W = 113
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Data only moves on a load, which keeps it stable while a stalled word waits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/p4_arbiter.sv
// Index-driven 4:1 packet arbiter: each accepted io_idx selects one input port,
// whose packets are forwarded in order up to and including the first non-empty one.
module p4_arbiter (
  input  logic        clock,
  input  logic        reset,

  input  logic        io_in_0_valid,
  output logic        io_in_0_ready,
  input  logic [15:0] io_in_0_bits_head_eth_type,
  input  logic [31:0] io_in_0_bits_head_next_idx,
  input  logic [31:0] io_in_0_bits_head_bitmap,
  input  logic [31:0] io_in_0_bits_head_index,
  input  logic        io_in_0_bits_is_empty,

  input  logic        io_in_1_valid,
  output logic        io_in_1_ready,
  input  logic [15:0] io_in_1_bits_head_eth_type,
  input  logic [31:0] io_in_1_bits_head_next_idx,
  input  logic [31:0] io_in_1_bits_head_bitmap,
  input  logic [31:0] io_in_1_bits_head_index,
  input  logic        io_in_1_bits_is_empty,

  input  logic        io_in_2_valid,
  output logic        io_in_2_ready,
  input  logic [15:0] io_in_2_bits_head_eth_type,
  input  logic [31:0] io_in_2_bits_head_next_idx,
  input  logic [31:0] io_in_2_bits_head_bitmap,
  input  logic [31:0] io_in_2_bits_head_index,
  input  logic        io_in_2_bits_is_empty,

  input  logic        io_in_3_valid,
  output logic        io_in_3_ready,
  input  logic [15:0] io_in_3_bits_head_eth_type,
  input  logic [31:0] io_in_3_bits_head_next_idx,
  input  logic [31:0] io_in_3_bits_head_bitmap,
  input  logic [31:0] io_in_3_bits_head_index,
  input  logic        io_in_3_bits_is_empty,

  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [15:0] io_out_bits_head_eth_type,
  output logic [31:0] io_out_bits_head_next_idx,
  output logic [31:0] io_out_bits_head_bitmap,
  output logic [31:0] io_out_bits_head_index,
  output logic        io_out_bits_is_empty,

  input  logic        io_idx_valid,
  output logic        io_idx_ready,
  input  logic [1:0]  io_idx_bits
);

  import p4_pkg::*;

  p4_state_t            state;
  logic [P4_IDX_W-1:0]  sel;
  logic                 idx_rdy;
  logic [P4_N_IN-1:0]   in_valid;
  logic [P4_N_IN-1:0]   in_ready;
  p4_pkt_t              in_pkt [P4_N_IN];
  p4_pkt_t              sel_pkt;
  p4_pkt_t              out_pkt;
  logic                 busy;
  logic                 sel_valid;
  logic                 slot_free;
  logic                 take;
  logic                 idx_fire;

  assign in_valid = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};

  assign in_pkt[0] = {io_in_0_bits_head_eth_type, io_in_0_bits_head_next_idx,
                      io_in_0_bits_head_bitmap, io_in_0_bits_head_index,
                      io_in_0_bits_is_empty};
  assign in_pkt[1] = {io_in_1_bits_head_eth_type, io_in_1_bits_head_next_idx,
                      io_in_1_bits_head_bitmap, io_in_1_bits_head_index,
                      io_in_1_bits_is_empty};
  assign in_pkt[2] = {io_in_2_bits_head_eth_type, io_in_2_bits_head_next_idx,
                      io_in_2_bits_head_bitmap, io_in_2_bits_head_index,
                      io_in_2_bits_is_empty};
  assign in_pkt[3] = {io_in_3_bits_head_eth_type, io_in_3_bits_head_next_idx,
                      io_in_3_bits_head_bitmap, io_in_3_bits_head_index,
                      io_in_3_bits_is_empty};

  assign busy      = (state == ST_BUSY);
  assign sel_pkt   = in_pkt[sel];
  assign sel_valid = busy && in_valid[sel];
  assign take      = sel_valid && slot_free;
  assign idx_fire  = io_idx_valid && idx_rdy;

  // Only the selected port sees ready, and only when the output slot can take a word.
  always_comb begin
    in_ready = '0;
    if (busy && slot_free) begin
      in_ready[sel] = 1'b1;
    end
  end

  assign io_in_0_ready = in_ready[0];
  assign io_in_1_ready = in_ready[1];
  assign io_in_2_ready = in_ready[2];
  assign io_in_3_ready = in_ready[3];
  assign io_idx_ready  = idx_rdy;

  // idx_rdy mirrors IDLE but is held low through reset, so it only rises on the
  // first clock after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sel     <= '0;
      idx_rdy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idx_fire) begin
            sel     <= io_idx_bits;
            state   <= ST_BUSY;
            idx_rdy <= 1'b0;
          end else begin
            idx_rdy <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (take && is_burst_end(sel_pkt)) begin
            state   <= ST_IDLE;
            idx_rdy <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          idx_rdy <= 1'b0;
        end
      endcase
    end
  end

  p4_reg_slice #(
    .W (P4_PKT_W)
  ) u_out_slice (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (sel_valid),
    .in_ready  (slot_free),
    .in_data   (sel_pkt),
    .out_valid (io_out_valid),
    .out_ready (io_out_ready),
    .out_data  (out_pkt)
  );

  assign io_out_bits_head_eth_type = out_pkt.head.eth_type;
  assign io_out_bits_head_next_idx = out_pkt.head.next_idx;
  assign io_out_bits_head_bitmap   = out_pkt.head.bitmap;
  assign io_out_bits_head_index    = out_pkt.head.index;
  assign io_out_bits_is_empty      = out_pkt.is_empty;

endmodule

// File: tb/tb_p4_arbiter.sv
// Self-checking bench for p4_arbiter: per-port packet sources, an idx command
// queue and a burst-level reference model that predicts the output stream.
module tb_p4_arbiter;

  import p4_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  p4_pkt_t     in_pkt [4];
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [15:0] out_eth;
  logic [31:0] out_nidx, out_bmp, out_index;
  logic        out_empty;
  logic        io_idx_valid = 1'b0;
  logic        io_idx_ready;
  logic [1:0]  io_idx_bits = '0;

  int      vectors = 0;
  int      fails = 0;
  p4_pkt_t src_q   [4][$];
  p4_pkt_t model_q [4][$];
  p4_pkt_t obs_q[$];
  p4_pkt_t exp_q[$];
  int      idx_q[$];
  bit      hold [4];
  bit      out_rand = 1'b0;
  bit      out_stall = 1'b0;
  bit      burst_open = 1'b0;
  int      active = 0;
  int      proto_err = 0;
  int      stall_err = 0;
  bit      prev_stall = 1'b0;
  p4_pkt_t prev_bits;
  p4_pkt_t cur;

  always #5 clock = ~clock;

  p4_arbiter dut (
    .clock                      (clock),
    .reset                      (reset),
    .io_in_0_valid              (in_valid[0]),
    .io_in_0_ready              (in_ready[0]),
    .io_in_0_bits_head_eth_type (in_pkt[0].head.eth_type),
    .io_in_0_bits_head_next_idx (in_pkt[0].head.next_idx),
    .io_in_0_bits_head_bitmap   (in_pkt[0].head.bitmap),
    .io_in_0_bits_head_index    (in_pkt[0].head.index),
    .io_in_0_bits_is_empty      (in_pkt[0].is_empty),
    .io_in_1_valid              (in_valid[1]),
    .io_in_1_ready              (in_ready[1]),
    .io_in_1_bits_head_eth_type (in_pkt[1].head.eth_type),
    .io_in_1_bits_head_next_idx (in_pkt[1].head.next_idx),
    .io_in_1_bits_head_bitmap   (in_pkt[1].head.bitmap),
    .io_in_1_bits_head_index    (in_pkt[1].head.index),
    .io_in_1_bits_is_empty      (in_pkt[1].is_empty),
    .io_in_2_valid              (in_valid[2]),
    .io_in_2_ready              (in_ready[2]),
    .io_in_2_bits_head_eth_type (in_pkt[2].head.eth_type),
    .io_in_2_bits_head_next_idx (in_pkt[2].head.next_idx),
    .io_in_2_bits_head_bitmap   (in_pkt[2].head.bitmap),
    .io_in_2_bits_head_index    (in_pkt[2].head.index),
    .io_in_2_bits_is_empty      (in_pkt[2].is_empty),
    .io_in_3_valid              (in_valid[3]),
    .io_in_3_ready              (in_ready[3]),
    .io_in_3_bits_head_eth_type (in_pkt[3].head.eth_type),
    .io_in_3_bits_head_next_idx (in_pkt[3].head.next_idx),
    .io_in_3_bits_head_bitmap   (in_pkt[3].head.bitmap),
    .io_in_3_bits_head_index    (in_pkt[3].head.index),
    .io_in_3_bits_is_empty      (in_pkt[3].is_empty),
    .io_out_valid               (io_out_valid),
    .io_out_ready               (io_out_ready),
    .io_out_bits_head_eth_type  (out_eth),
    .io_out_bits_head_next_idx  (out_nidx),
    .io_out_bits_head_bitmap    (out_bmp),
    .io_out_bits_head_index     (out_index),
    .io_out_bits_is_empty       (out_empty),
    .io_idx_valid               (io_idx_valid),
    .io_idx_ready               (io_idx_ready),
    .io_idx_bits                (io_idx_bits)
  );

  function automatic p4_pkt_t mk_pkt(input int port, input bit empty, input bit rnd_eth);
    p4_pkt_t p;
    p.head.eth_type = rnd_eth ? 16'($urandom) : 16'(port);
    p.head.next_idx = $urandom;
    p.head.bitmap   = $urandom;
    p.head.index    = $urandom;
    p.is_empty      = empty;
    return p;
  endfunction

  task automatic push_pkt(input int port, input bit empty, input bit rnd_eth);
    p4_pkt_t p;
    p = mk_pkt(port, empty, rnd_eth);
    src_q[port].push_back(p);
    model_q[port].push_back(p);
  endtask

  // One clock: drive at negedge, sample handshakes shortly before the posedge.
  task automatic tick();
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = (src_q[k].size() > 0) && !hold[k];
      in_pkt[k]   = (src_q[k].size() > 0) ? src_q[k][0] : '0;
    end
    io_idx_valid = (idx_q.size() > 0);
    io_idx_bits  = (idx_q.size() > 0) ? 2'(idx_q[0]) : 2'd0;
    io_out_ready = out_stall ? 1'b0 : (out_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #2;
    cur = {out_eth, out_nidx, out_bmp, out_index, out_empty};
    if (prev_stall && (!io_out_valid || cur !== prev_bits)) stall_err++;
    if (io_idx_ready && burst_open) proto_err++;
    for (int k = 0; k < 4; k++) begin
      if (in_ready[k] && (!burst_open || k != active)) proto_err++;
    end
    for (int k = 0; k < 4; k++) begin
      if (in_valid[k] && in_ready[k]) begin
        if (!src_q[k][0].is_empty) burst_open = 1'b0;
        void'(src_q[k].pop_front());
      end
    end
    if (io_out_valid && io_out_ready) obs_q.push_back(cur);
    if (io_idx_valid && io_idx_ready) begin
      p4_pkt_t p;
      active     = int'(io_idx_bits);
      burst_open = 1'b1;
      void'(idx_q.pop_front());
      while (model_q[active].size() > 0) begin
        p = model_q[active].pop_front();
        exp_q.push_back(p);
        if (!p.is_empty) break;
      end
    end
    prev_stall = io_out_valid && !io_out_ready;
    prev_bits  = cur;
  endtask

  task automatic run(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (idx_q.size() == 0 && !burst_open && obs_q.size() == exp_q.size()) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_test();
    obs_q.delete();
    exp_q.delete();
    proto_err = 0;
    stall_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    cur = {out_eth, out_nidx, out_bmp, out_index, out_empty};
    vectors++; if (io_out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %b want 0", io_out_valid); end
    vectors++; if (cur !== '0) begin fails++; $display("[TB] FAIL reset_out_bits got %h want 0", cur); end
    vectors++; if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_in_ready got %b want 0000", in_ready); end
    vectors++; if (io_idx_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_idx_ready got %b want 0", io_idx_ready); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    vectors++; if (io_idx_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_idx_ready got %b want 1", io_idx_ready); end
  endtask

  task automatic test_single_burst();
    bit to;
    start_test();
    push_pkt(0, 1'b0, 1'b0);
    idx_q.push_back(0);
    run(40, to);
    vectors++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL single_timeout got %0d want 0", to); end
    vectors++; if (obs_q.size() !== 1) begin fails++; $display("[TB] FAIL single_count got %0d want 1", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL single_pkt%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    tick();
    vectors++; if (io_idx_ready !== 1'b1) begin fails++; $display("[TB] FAIL single_back_to_idle got %b want 1", io_idx_ready); end
    vectors++; if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL single_idle_ready got %b want 0000", in_ready); end
    vectors++; if (proto_err !== 0) begin fails++; $display("[TB] FAIL single_protocol got %0d want 0", proto_err); end
  endtask

  task automatic test_multi_burst();
    bit to;
    start_test();
    push_pkt(3, 1'b1, 1'b0);
    push_pkt(3, 1'b1, 1'b0);
    push_pkt(3, 1'b0, 1'b0);
    push_pkt(0, 1'b0, 1'b0);
    idx_q.push_back(3);
    idx_q.push_back(0);
    run(80, to);
    vectors++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL multi_timeout got %0d want 0", to); end
    vectors++; if (obs_q.size() !== 4) begin fails++; $display("[TB] FAIL multi_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL multi_pkt%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    if (obs_q.size() >= 3) begin
      vectors++;
      if ({obs_q[0].is_empty, obs_q[1].is_empty, obs_q[2].is_empty} !== 3'b110) begin
        fails++; $display("[TB] FAIL multi_flags got %b%b%b want 110", obs_q[0].is_empty, obs_q[1].is_empty, obs_q[2].is_empty);
      end
    end
    vectors++; if (proto_err !== 0) begin fails++; $display("[TB] FAIL multi_idx_stall got %0d want 0", proto_err); end
  endtask

  task automatic test_mixed();
    bit to;
    int flags0[$] = '{0, 1, 0};
    int flags1[$] = '{1, 1, 0, 1, 1};
    int flags2[$] = '{0, 1, 1};
    int flags3[$] = '{1, 1, 0};
    int eth_exp[$] = '{0, 2, 1, 1, 1, 3, 3, 3, 0, 0};
    start_test();
    foreach (flags0[i]) push_pkt(0, flags0[i][0], 1'b0);
    foreach (flags1[i]) push_pkt(1, flags1[i][0], 1'b0);
    foreach (flags2[i]) push_pkt(2, flags2[i][0], 1'b0);
    foreach (flags3[i]) push_pkt(3, flags3[i][0], 1'b0);
    idx_q = '{0, 2, 1, 3, 0};
    run(200, to);
    vectors++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL mixed_timeout got %0d want 0", to); end
    vectors++; if (obs_q.size() !== eth_exp.size()) begin fails++; $display("[TB] FAIL mixed_count got %0d want %0d", obs_q.size(), eth_exp.size()); end
    for (int i = 0; i < eth_exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (int'(obs_q[i].head.eth_type) !== eth_exp[i]) begin
        fails++; $display("[TB] FAIL mixed_eth%0d got %0d want %0d", i, obs_q[i].head.eth_type, eth_exp[i]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL mixed_pkt%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++; if (src_q[1].size() !== 2) begin fails++; $display("[TB] FAIL mixed_left1 got %0d want 2", src_q[1].size()); end
    vectors++; if (src_q[2].size() !== 2) begin fails++; $display("[TB] FAIL mixed_left2 got %0d want 2", src_q[2].size()); end
    vectors++; if (proto_err !== 0) begin fails++; $display("[TB] FAIL mixed_protocol got %0d want 0", proto_err); end
  endtask

  task automatic test_backpressure();
    bit to;
    int p, len;
    start_test();
    out_rand = 1'b1;
    for (int b = 0; b < 10; b++) begin
      p   = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) push_pkt(p, j < len - 1, 1'b1);
      idx_q.push_back(p);
    end
    run(800, to);
    out_rand = 1'b0;
    vectors++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL bp_timeout got %0d want 0", to); end
    vectors++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("[TB] FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL bp_pkt%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++; if (stall_err !== 0) begin fails++; $display("[TB] FAIL bp_stable got %0d want 0", stall_err); end
    vectors++; if (proto_err !== 0) begin fails++; $display("[TB] FAIL bp_protocol got %0d want 0", proto_err); end
  endtask

  task automatic test_empty_port();
    bit to;
    start_test();
    hold[2] = 1'b1;
    push_pkt(2, 1'b0, 1'b0);
    push_pkt(0, 1'b0, 1'b0);
    idx_q.push_back(2);
    repeat (50) tick();
    vectors++; if (obs_q.size() !== 0) begin fails++; $display("[TB] FAIL wait_no_output got %0d want 0", obs_q.size()); end
    vectors++; if (idx_q.size() !== 0) begin fails++; $display("[TB] FAIL wait_idx_taken got %0d want 0", idx_q.size()); end
    vectors++; if (io_idx_ready !== 1'b0) begin fails++; $display("[TB] FAIL wait_busy got %b want 0", io_idx_ready); end
    vectors++; if (in_ready !== 4'b0100) begin fails++; $display("[TB] FAIL wait_ready got %b want 0100", in_ready); end
    hold[2] = 1'b0;
    run(100, to);
    vectors++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL wait_timeout got %0d want 0", to); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL wait_pkt%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++; if (src_q[0].size() !== 1) begin fails++; $display("[TB] FAIL wait_port0_kept got %0d want 1", src_q[0].size()); end
    vectors++; if (proto_err !== 0) begin fails++; $display("[TB] FAIL wait_protocol got %0d want 0", proto_err); end
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    bit seen = 1'b0;
    start_test();
    out_stall = 1'b1;
    push_pkt(1, 1'b1, 1'b0);
    push_pkt(1, 1'b1, 1'b0);
    push_pkt(1, 1'b1, 1'b0);
    push_pkt(1, 1'b0, 1'b0);
    idx_q.push_back(1);
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      seen = io_out_valid;
    end
    vectors++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL rmid_out_valid_before got %b want 1", seen); end
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    cur = {out_eth, out_nidx, out_bmp, out_index, out_empty};
    vectors++; if (io_out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rmid_out_valid got %b want 0", io_out_valid); end
    vectors++; if (cur !== '0) begin fails++; $display("[TB] FAIL rmid_out_bits got %h want 0", cur); end
    vectors++; if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL rmid_in_ready got %b want 0000", in_ready); end
    vectors++; if (io_idx_ready !== 1'b0) begin fails++; $display("[TB] FAIL rmid_idx_ready got %b want 0", io_idx_ready); end
    for (int k = 0; k < 4; k++) begin
      src_q[k].delete();
      model_q[k].delete();
    end
    idx_q.delete();
    burst_open = 1'b0;
    prev_stall = 1'b0;
    out_stall  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    vectors++; if (io_idx_ready !== 1'b1) begin fails++; $display("[TB] FAIL rmid_idx_after got %b want 1", io_idx_ready); end
    start_test();
    push_pkt(2, 1'b1, 1'b1);
    push_pkt(2, 1'b0, 1'b1);
    idx_q.push_back(2);
    run(60, to);
    vectors++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL rmid_recover_timeout got %0d want 0", to); end
    vectors++; if (obs_q.size() !== 2) begin fails++; $display("[TB] FAIL rmid_recover_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL rmid_pkt%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_pkt[k] = '0;
      hold[k]   = 1'b0;
    end
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_mixed();
    test_backpressure();
    test_empty_port();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
